// File: rtl/mult_seq_param.sv
// Iterative shift-add multiplier with signed/unsigned modes, valid/ready handshakes on both sides and a flush.
// Operands are reduced to magnitudes on accept; the sign is reapplied once, when the product is registered.
module mult_seq_param #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    // state | meaning
    // IDLE  | waiting for operands, in_ready=1
    // CALC  | one shift-add iteration per cycle, WIDTH cycles
    // FIN   | apply sign and register the product
    // DONE  | product held until out_ready
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mag_a_q, mag_a_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 out_valid_q, out_valid_d;

    logic [WIDTH-1:0]     mag_a_in, mag_b_in, addend;
    logic [WIDTH:0]       sum;

    always_comb begin
        mag_a_in = (signed_mode && op_a[WIDTH-1]) ? (~op_a + {{(WIDTH-1){1'b0}}, 1'b1}) : op_a;
        mag_b_in = (signed_mode && op_b[WIDTH-1]) ? (~op_b + {{(WIDTH-1){1'b0}}, 1'b1}) : op_b;
        addend   = acc_q[0] ? mag_a_q : {WIDTH{1'b0}};
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        mag_a_d     = mag_a_q;
        neg_d       = neg_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;

        if (flush) begin
            state_d     = S_IDLE;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        mag_a_d = mag_a_in;
                        neg_d   = signed_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        acc_d   = {{WIDTH{1'b0}}, mag_b_in};
                        count_d = '0;
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    // carry-out lands in the MSB, so the full 2*WIDTH result survives
                    acc_d   = {sum, acc_q[WIDTH-1:1]};
                    count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIN;
                    end
                end
                S_FIN: begin
                    product_d   = neg_q ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            mag_a_q     <= '0;
            neg_q       <= 1'b0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            mag_a_q     <= mag_a_d;
            neg_q       <= neg_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_CALC) || (state_q == S_FIN);
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule
